// File: rtl/da_row_sequencer.sv
// Frame controller for the bit-serial DA row engine: latches one input vector,
// then clears, runs and collects the engine once per row, streaming tagged results.
module da_row_sequencer #(
  parameter int unsigned ROWS    = 8,
  parameter int unsigned XW      = 8,
  parameter int unsigned YW      = 19,
  parameter int unsigned RW      = 5,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [8*XW-1:0]   in_x_i,
  output logic [8*XW-1:0]   core_x_o,
  output logic              core_rst_o,
  output logic              core_start_o,
  output logic [RW-1:0]     core_row_o,
  input  logic              core_done_i,
  input  logic [YW-1:0]     core_y_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [YW-1:0]     out_y_o,
  output logic [RW-1:0]     out_row_o,
  output logic              out_last_o,
  output logic              busy_o,
  output logic              err_timeout_o
);

  localparam int unsigned XVW = 8 * XW;
  localparam int unsigned TW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, OUT} state_e;

  state_e          state_q, state_d;
  logic [RW-1:0]   row_cnt_q, row_cnt_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [XVW-1:0]  x_q, x_d;
  logic [YW-1:0]   out_y_q, out_y_d;
  logic [RW-1:0]   out_row_q, out_row_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;
  logic            timed_out;
  logic            last_row;

  assign timed_out = (timer_q == TW'(TIMEOUT - 1));
  assign last_row  = (row_cnt_q == RW'(ROWS - 1));

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_cnt_q  <= '0;
      timer_q    <= '0;
      x_q        <= '0;
      out_y_q    <= '0;
      out_row_q  <= '0;
      out_last_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      timer_q    <= timer_d;
      x_q        <= x_d;
      out_y_q    <= out_y_d;
      out_row_q  <= out_row_d;
      out_last_q <= out_last_d;
      err_q      <= err_d;
    end
  end

  // Next state and next register values
  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    timer_d    = timer_q;
    x_d        = x_q;
    out_y_d    = out_y_q;
    out_row_d  = out_row_q;
    out_last_d = out_last_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          x_d       = in_x_i;
          row_cnt_d = '0;
          state_d   = CLR;
        end
      end
      CLR: begin
        timer_d = '0;
        state_d = RUN;
      end
      RUN: begin
        timer_d = timer_q + TW'(1);
        // A done in the same cycle as the timeout wins
        if (core_done_i) begin
          out_y_d    = core_y_i;
          out_row_d  = row_cnt_q;
          out_last_d = last_row;
          state_d    = OUT;
        end else if (timed_out) begin
          err_d      = 1'b1;
          out_y_d    = '0;
          out_row_d  = row_cnt_q;
          out_last_d = last_row;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready_i) begin
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            row_cnt_d = row_cnt_q + RW'(1);
            state_d   = CLR;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    core_rst_o    = reset | (state_q == CLR);
    core_start_o  = (state_q == RUN);
    in_ready_o    = (state_q == IDLE) & ~reset;
    out_valid_o   = (state_q == OUT);
    busy_o        = (state_q != IDLE);
    core_row_o    = row_cnt_q;
    core_x_o      = x_q;
    out_y_o       = out_y_q;
    out_row_o     = out_row_q;
    out_last_o    = out_last_q;
    err_timeout_o = err_q;
  end

endmodule

// File: tb/tb_da_row_sequencer.sv
// Self-checking bench for da_row_sequencer with a behavioural DA engine model
// and a scoreboard of expected row results.
module tb_da_row_sequencer;

  typedef struct packed {
    logic [18:0] y;
    logic [4:0]  row;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_x = '0;
  logic [63:0] core_x;
  logic        core_rst, core_start;
  logic [4:0]  core_row;
  logic        core_done;
  logic [18:0] core_y;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [18:0] out_y;
  logic [4:0]  out_row;
  logic        out_last, busy, err_timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int supp_row = -1;
  int hs_count = 0;
  int start_rises = 0;
  int stale_viol = 0;
  int stab_viol = 0;
  exp_t exp_q[$];

  da_row_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .in_x_i(in_x),
    .core_x_o(core_x), .core_rst_o(core_rst), .core_start_o(core_start),
    .core_row_o(core_row), .core_done_i(core_done), .core_y_i(core_y),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_y_o(out_y),
    .out_row_o(out_row), .out_last_o(out_last), .busy_o(busy),
    .err_timeout_o(err_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Engine model: done 9 cycles after start rises, sticky until core_rst
  logic [3:0] ecnt = '0;
  always @(posedge clk) begin
    if (core_rst) ecnt <= '0;
    else if (core_start && ecnt != 4'd15) ecnt <= ecnt + 4'd1;
  end
  assign core_done = (ecnt >= 4'd9) && (int'(core_row) != supp_row);
  assign core_y    = 19'(int'(core_row) * 1000 + int'(core_x[7:0]));

  always @(posedge clk) if (!reset && out_valid && out_ready) hs_count++;

  // Protocol monitors: clear-before-run and engine input stability
  logic        prev_rst = 1'b0, prev_start = 1'b0, prev_hold = 1'b0;
  logic [4:0]  prev_row = '0;
  logic [63:0] prev_x = '0;
  always @(negedge clk) begin
    if (core_start && !prev_start) begin
      start_rises++;
      if (!prev_rst) stale_viol++;
    end
    if (!reset && prev_hold && (core_rst || core_start) &&
        (core_row !== prev_row || core_x !== prev_x)) stab_viol++;
    prev_hold  = !reset && (core_rst || core_start);
    prev_rst   = core_rst;
    prev_start = core_start;
    prev_row   = core_row;
    prev_x     = core_x;
  end

  task automatic send_vec(input logic [63:0] x, output int acc);
    int w = 0;
    exp_t e;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_vec: in_ready stayed %0b, want 1", in_ready);
    end
    in_valid = 1'b1;
    in_x = x;
    for (int r = 0; r < 8; r++) begin
      e.y    = (r == supp_row) ? 19'd0 : 19'(r * 1000 + int'(x[7:0]));
      e.row  = 5'(r);
      e.last = (r == 7);
      exp_q.push_back(e);
    end
    @(negedge clk);
    acc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic get_out(output exp_t o, output bit ok);
    ok = 1'b0;
    o = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (out_valid) begin
        o = {out_y, out_row, out_last};
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic drain_rows(input int n, input string tag);
    exp_t o, e;
    bit ok;
    for (int i = 0; i < n; i++) begin
      get_out(o, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: no out_valid within 200 cycles, got 0 want 1", tag);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL %s: unexpected result y=%0d row=%0d", tag, o.y, o.row);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL %s: got y=%0d row=%0d last=%0b want y=%0d row=%0d last=%0b",
                   tag, o.y, o.row, o.last, e.y, e.row, e.last);
        end
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({core_rst, in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_active: core_rst,in_ready=%b want 10", {core_rst, in_ready});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, err_timeout, out_last, core_start, core_rst, in_ready} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_flags: got %b want 0000001",
               {out_valid, busy, err_timeout, out_last, core_start, core_rst, in_ready});
    end
    checks++;
    if ({out_y, out_row, core_x, core_row} !== '0) begin
      errors++;
      $display("FAIL reset_data: out_y=%0d out_row=%0d core_x=%h core_row=%0d want all 0",
               out_y, out_row, core_x, core_row);
    end
  endtask

  task automatic test_basic_frame();
    int acc;
    exp_t o, e;
    bit ok;
    send_vec(64'h0102030405060705, acc);
    get_out(o, ok);
    checks++;
    if (!ok || cyc - acc != 11) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles want 11", cyc - acc);
    end
    e = exp_q.pop_front();
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL basic_row0: got y=%0d row=%0d last=%0b want y=%0d row=%0d last=%0b",
               o.y, o.row, o.last, e.y, e.row, e.last);
    end
    drain_rows(7, "basic");
    @(negedge clk);
    checks++;
    if ({in_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL basic_idle: in_ready,busy=%b want 10", {in_ready, busy});
    end
  endtask

  task automatic test_stale_done();
    int acc, h0;
    start_rises = 0; stale_viol = 0; stab_viol = 0;
    h0 = hs_count;
    send_vec(64'h00000000000000C8, acc);
    drain_rows(8, "stale");
    repeat (5) @(negedge clk);
    checks++;
    if (start_rises != 8 || stale_viol != 0) begin
      errors++;
      $display("FAIL stale_clr: runs=%0d unprefixed=%0d want 8 and 0", start_rises, stale_viol);
    end
    checks++;
    if (hs_count - h0 != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stale_once: handshakes=%0d left=%0d want 8 and 0", hs_count - h0, exp_q.size());
    end
    checks++;
    if (stab_viol != 0) begin
      errors++;
      $display("FAIL stable_inputs: changes=%0d want 0", stab_viol);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    exp_t o, e;
    bit ok;
    send_vec(64'h0000000000000005, acc);
    drain_rows(3, "bp_pre");
    @(negedge clk);
    out_ready = 1'b0;
    get_out(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o !== e) begin
      errors++;
      $display("FAIL bp_row3: got y=%0d row=%0d want y=%0d row=%0d", o.y, o.row, e.y, e.row);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, out_y, out_row, core_start} !== {1'b1, 19'd3005, 5'd3, 1'b0}) begin
        errors++;
        $display("FAIL bp_hold: valid=%0b y=%0d row=%0d start=%0b want 1 3005 3 0",
                 out_valid, out_y, out_row, core_start);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_rst, core_start, out_valid, core_row} !== {3'b100, 5'd4}) begin
      errors++;
      $display("FAIL bp_clr: rst,start,valid=%b row=%0d want 100 4",
               {core_rst, core_start, out_valid}, core_row);
    end
    @(negedge clk);
    checks++;
    if ({core_rst, core_start} !== 2'b01) begin
      errors++;
      $display("FAIL bp_run: rst,start=%b want 01", {core_rst, core_start});
    end
    drain_rows(4, "bp_post");
  endtask

  task automatic test_busy_input();
    int acc;
    logic [63:0] xa;
    xa = 64'h1122334455667705;
    send_vec(xa, acc);
    in_valid = 1'b1;
    in_x = 64'hAAAAAAAAAAAAAAC8;
    drain_rows(1, "busy");
    checks++;
    if (in_ready !== 1'b0 || core_x !== xa) begin
      errors++;
      $display("FAIL busy_ignore: in_ready=%0b core_x=%h want 0 %h", in_ready, core_x, xa);
    end
    drain_rows(6, "busy");
    in_valid = 1'b0;
    drain_rows(1, "busy");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || core_x !== xa) begin
      errors++;
      $display("FAIL busy_end: busy=%0b core_x=%h want 0 %h", busy, core_x, xa);
    end
  endtask

  task automatic test_timeout();
    int acc, c1;
    exp_t o, e;
    bit ok;
    supp_row = 2;
    send_vec(64'h0000000000000007, acc);
    drain_rows(2, "to_pre");
    c1 = cyc;
    checks++;
    if (err_timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_early: err_timeout=%0b want 0", err_timeout);
    end
    get_out(o, ok);
    e = exp_q.pop_front();
    checks++;
    if (!ok || o !== e || cyc - c1 != 18) begin
      errors++;
      $display("FAIL to_row2: got y=%0d row=%0d after %0d cycles want y=%0d row=%0d after 18",
               o.y, o.row, cyc - c1, e.y, e.row);
    end
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_flag: err_timeout=%0b want 1", err_timeout);
    end
    supp_row = -1;
    drain_rows(5, "to_post");
    checks++;
    if (err_timeout !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: err_timeout=%0b want 1", err_timeout);
    end
  endtask

  task automatic test_reset_midframe();
    int acc, h0, w;
    send_vec(64'h0000000000000005, acc);
    drain_rows(4, "rst_pre");
    w = 0;
    while (!(core_row == 5'd4 && core_start) && w < 100) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (!(core_row == 5'd4 && core_start)) begin
      errors++;
      $display("FAIL rst_reach: row=%0d start=%0b want 4 1", core_row, core_start);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({core_rst, in_ready, out_valid, busy, err_timeout} !== 5'b10000) begin
      errors++;
      $display("FAIL rst_mid: rst,ready,valid,busy,err=%b want 10000",
               {core_rst, in_ready, out_valid, busy, err_timeout});
    end
    reset = 1'b0;
    exp_q.delete();
    h0 = hs_count;
    repeat (20) @(negedge clk);
    checks++;
    if (hs_count != h0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_partial: extra results=%0d valid=%0b want 0 0", hs_count - h0, out_valid);
    end
    send_vec(64'h0000000000000009, acc);
    drain_rows(8, "rst_new");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic_frame();
    test_stale_done();
    test_backpressure();
    test_busy_input();
    test_timeout();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
